// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (LEN_LO, LEN_HI, 4*LEN data bytes, CHK)
// over a valid/ready handshake. It packs the data bytes little-endian into
// 32-bit words and writes them to the IMEM write port. The core is held in
// reset until an image has loaded and its XOR checksum has matched.
module imem_loader #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
   } state_t;

   localparam logic [15:0] MAX_LEN = 16'(DEPTH);

   state_t              r_state;
   logic [15:0]         r_len;
   logic [1:0]          r_lane;
   logic [23:0]         r_word;       // lanes 0..2 of the word being packed
   logic [7:0]          r_chk;
   logic                r_rx_ready;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_core_rst;
   logic                r_busy;
   logic                r_done;
   logic                r_error;
   logic [ADDR_W:0]     r_word_cnt;

   logic                w_xfer;
   logic [15:0]         w_len_full;
   logic                w_len_bad;
   logic [ADDR_W:0]     w_cnt_next;

   // Handshake, full length as it is being latched, and the next word count.
   assign w_xfer     = rx_valid & r_rx_ready;
   assign w_len_full = {rx_data, r_len[7:0]};
   assign w_len_bad  = (w_len_full == 16'd0) || (w_len_full > MAX_LEN);
   assign w_cnt_next = r_word_cnt + (ADDR_W+1)'(1);

   // Session FSM; every output is registered and updated on the state edges.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_lane     <= '0;
         r_word     <= '0;
         r_chk      <= '0;
         r_rx_ready <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_core_rst <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_word_cnt <= '0;
      end else begin
         r_we <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state    <= S_LEN_LO;
                  r_rx_ready <= 1'b1;
                  r_core_rst <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_word_cnt <= '0;
                  r_lane     <= '0;
                  r_chk      <= '0;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= rx_data;
                  r_state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= rx_data;
                  if (w_len_bad) begin
                     r_state    <= S_ERR;
                     r_rx_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_chk  <= r_chk ^ rx_data;
                  r_lane <= r_lane + 2'd1;
                  unique case (r_lane)
                     2'd0: r_word[7:0]   <= rx_data;
                     2'd1: r_word[15:8]  <= rx_data;
                     2'd2: r_word[23:16] <= rx_data;
                     default: begin
                        r_we       <= 1'b1;
                        r_addr     <= r_word_cnt[ADDR_W-1:0];
                        r_wdata    <= {rx_data, r_word};
                        r_word_cnt <= w_cnt_next;
                        if (w_cnt_next == r_len[ADDR_W:0]) begin
                           r_state <= S_CHECK;
                        end
                     end
                  endcase
               end
            end
            S_CHECK: begin
               if (w_xfer) begin
                  r_rx_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  if (rx_data == r_chk) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_core_rst <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     r_error <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_ready   = r_rx_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign core_rst   = r_core_rst;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: byte streams are built per scenario, driven with
// optional random valid gaps, and the observed IMEM writes and final status are
// compared with a stream-parsing reference model.
module tb_imem_loader;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  stream_q[$];
   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst(core_rst), .busy(busy), .done(done), .error(error),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // Write monitor: logs every IMEM write; a write is only legal mid-session.
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         wr_addr_q.push_back(int'(imem_addr));
         wr_data_q.push_back(imem_wdata);
         n_checks++;
         if (busy !== 1'b1)
            $display("FAIL we_outside_session: busy=%b required 1", busy);
         else
            n_pass++;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
      int t;
      if (with_start) pulse_start();
      for (int g = 0; g < gap; g++) begin
         rx_data = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      t = 0;
      while (rx_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (rx_ready !== 1'b1) begin
         n_checks++;
         $display("FAIL rx_ready_timeout: rx_ready=%b required 1 within 50 cycles", rx_ready);
      end else begin
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   // Start a session, stream stream_q, then compare against the model.
   task automatic run_session(input string name, input int max_gap, input int start_at);
      int          len, nwords;
      bit          exp_ok;
      logic [7:0]  x;
      logic [31:0] w;
      logic [31:0] exp_words[$];
      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start();
      n_checks++;
      if ({core_rst, busy, done, error, rx_ready, word_cnt} !== {5'b11001, 11'd0})
         $display("FAIL %s_after_start: rst/busy/done/err/rdy/cnt=%b%b%b%b%b/%0d required 11001/0",
                  name, core_rst, busy, done, error, rx_ready, word_cnt);
      else n_pass++;

      for (int i = 0; i < stream_q.size(); i++)
         send_byte(stream_q[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0, (i == start_at));
      repeat (3) @(negedge clk);

      // Reference model: parse the stream by its format rules.
      len = int'(stream_q[0]) | (int'(stream_q[1]) << 8);
      exp_words.delete();
      if (len == 0 || len > DEPTH) begin
         exp_ok = 1'b0;
      end else begin
         x = 8'h00;
         for (int k = 0; k < len; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
               w = w | (32'(stream_q[2 + 4*k + j]) << (8*j));
               x = x ^ stream_q[2 + 4*k + j];
            end
            exp_words.push_back(w);
         end
         exp_ok = (stream_q[2 + 4*len] == x);
      end
      nwords = exp_words.size();

      n_checks++;
      if (wr_addr_q.size() != nwords)
         $display("FAIL %s_write_count: got %0d required %0d", name, wr_addr_q.size(), nwords);
      else n_pass++;
      for (int k = 0; k < nwords && k < wr_addr_q.size(); k++) begin
         n_checks++;
         if (wr_addr_q[k] != k || wr_data_q[k] !== exp_words[k])
            $display("FAIL %s_write%0d: got [%0d]=%08h required [%0d]=%08h",
                     name, k, wr_addr_q[k], wr_data_q[k], k, exp_words[k]);
         else n_pass++;
      end
      n_checks++;
      if (done !== exp_ok || error !== !exp_ok || core_rst !== !exp_ok || busy !== 1'b0
          || rx_ready !== 1'b0 || word_cnt !== 11'(nwords))
         $display("FAIL %s_status: done=%b err=%b core_rst=%b busy=%b rdy=%b cnt=%0d required done=%b err=%b core_rst=%b busy=0 rdy=0 cnt=%0d",
                  name, done, error, core_rst, busy, rx_ready, word_cnt,
                  exp_ok, !exp_ok, !exp_ok, nwords);
      else n_pass++;
   endtask

   task automatic load_test1(input logic [7:0] chk);
      stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'hB3, 8'h02, 8'h32, 8'h00, chk};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, error, word_cnt}
          !== {2'b00, 10'd0, 32'd0, 4'b1000, 11'd0})
         $display("FAIL reset_state: rdy=%b we=%b addr=%0d wdata=%08h rst=%b busy=%b done=%b err=%b cnt=%0d required 0 0 0 0 1 0 0 0 0",
                  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, error, word_cnt);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      load_test1(8'h90);
      run_session("basic", 0, -1);
      load_test1(8'h91);
      run_session("bad_chk", 0, -1);
   endtask

   task automatic test_bad_len();
      stream_q = '{8'h00, 8'h00};
      run_session("len_zero", 0, -1);
      stream_q = '{8'h01, 8'h04};
      run_session("len_1025", 0, -1);
      for (int r = 0; r < 3; r++) begin
         stream_q = '{8'($urandom), 8'($urandom_range(5, 255))};
         run_session("len_rand_big", 1, -1);
      end
   endtask

   task automatic test_gaps_and_start();
      for (int r = 0; r < 3; r++) begin
         load_test1(8'h90);
         run_session("gaps_start", 3, $urandom_range(3, 10));
      end
   endtask

   task automatic test_random();
      int          len;
      logic [7:0]  x, b;
      for (int r = 0; r < 12; r++) begin
         len = $urandom_range(1, 6);
         stream_q = '{8'(len), 8'h00};
         x = 8'h00;
         for (int k = 0; k < 4*len; k++) begin
            b = 8'($urandom);
            x = x ^ b;
            stream_q.push_back(b);
         end
         if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
         stream_q.push_back(x);
         run_session("random", $urandom_range(0, 2), ($urandom_range(0, 1) != 0) ? 5 : -1);
      end
   endtask

   task automatic test_full_depth();
      logic [7:0] x, b;
      stream_q = '{8'(DEPTH & 8'hFF), 8'(DEPTH >> 8)};
      x = 8'h00;
      for (int k = 0; k < 4*DEPTH; k++) begin
         b = 8'($urandom);
         x = x ^ b;
         stream_q.push_back(b);
      end
      stream_q.push_back(x);
      run_session("full_depth", 0, -1);
   endtask

   task automatic test_reset_mid_load();
      pulse_start();
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'hAA, 0, 1'b0);
      send_byte(8'hBB, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, error, word_cnt}
          !== {2'b00, 10'd0, 32'd0, 4'b1000, 11'd0})
         $display("FAIL async_reset: rdy=%b we=%b addr=%0d wdata=%08h rst=%b busy=%b done=%b err=%b cnt=%0d required 0 0 0 0 1 0 0 0 0",
                  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, error, word_cnt);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      stream_q = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
      run_session("after_reset", 0, -1);
   endtask

   task automatic test_back_to_back();
      load_test1(8'h90);
      run_session("b2b_first", 0, -1);
      stream_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      run_session("b2b_deadbeef", 0, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_len();
      test_gaps_and_start();
      test_random();
      test_full_depth();
      test_reset_mid_load();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
